alu_instr_encoder: RTL and testbench

- Converts ALU operation requests into 32-bit RV32I instruction words. This is the encode direction of the ALUControl / funct3 / funct7 / opcode mapping used by the CPU's decoders.
- Sits between the test-program sequencer and instruction-memory preload.
- Accepts one request per cycle over a valid/ready handshake and buffers encoded words in a 2-entry output FIFO.
- Tags each emitted word with an auto-incrementing byte address.
- Rejects illegal requests with an error pulse.

---
 rtl/alu_instr_encoder.sv | 117 +++++++++++
 tb/tb_alu_instr_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_encoder.sv
// Encodes ALU/load/store/branch requests into RV32I instruction words and
// queues them, tagged with an auto-incrementing byte address, in a 2-deep FIFO.
module alu_instr_encoder #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_kind,
   input  logic [2:0]        in_alu,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [12:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err,
   output logic [15:0]       emitted
);

   typedef struct packed {
      logic [31:0]       instr;
      logic [ADDR_W-1:0] addr;
   } entry_t;

   localparam logic [1:0] K_LW  = 2'b00;
   localparam logic [1:0] K_SW  = 2'b01;
   localparam logic [1:0] K_ALU = 2'b10;

   entry_t            head_q, tail_q, new_e;
   logic [1:0]        cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       enc;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic              illegal;
   logic              accept, push, pop;

   always_comb begin
      f3      = 3'b000;
      f7      = 7'b0000000;
      illegal = 1'b0;
      case (in_alu)
         3'b000: f3 = 3'b000;
         3'b001: begin f3 = 3'b000; f7 = 7'b0100000; end
         3'b010: f3 = 3'b111;
         3'b011: f3 = 3'b110;
         3'b100: f3 = 3'b010;
         default: illegal = (in_kind == K_ALU);
      endcase
      case (in_kind)
         K_LW:  enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
         K_SW:  enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
         K_ALU: enc = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
         default: begin
            enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                   in_imm[4:1], in_imm[11], 7'b1100011};
            // Branch offsets are halfword-aligned; an odd offset cannot be encoded.
            illegal = in_imm[0];
         end
      endcase
   end

   assign new_e     = '{instr: enc, addr: addr_q};
   assign out_valid = (cnt_q != 2'd0);
   assign pop       = out_valid & out_ready & ~restart;
   assign in_ready  = ~restart & ((cnt_q != 2'd2) | (out_valid & out_ready));
   assign accept    = in_valid & in_ready;
   assign push      = accept & ~illegal;
   assign out_instr = head_q.instr;
   assign out_addr  = head_q.addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '{instr: 32'h0, addr: BASE_ADDR};
         tail_q  <= '{instr: 32'h0, addr: BASE_ADDR};
         cnt_q   <= 2'd0;
         addr_q  <= BASE_ADDR;
         err     <= 1'b0;
         emitted <= 16'h0;
      end else if (restart) begin
         cnt_q  <= 2'd0;
         addr_q <= BASE_ADDR;
         err    <= 1'b0;
      end else begin
         err <= accept & illegal;
         if (push) addr_q <= addr_q + ADDR_W'(3'd4);
         if (pop)  emitted <= emitted + 16'd1;
         case ({push, pop})
            2'b10: begin
               if (cnt_q == 2'd0) head_q <= new_e;
               else               tail_q <= new_e;
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               head_q <= tail_q;
               cnt_q  <= cnt_q - 2'd1;
            end
            2'b11: begin
               // Occupancy is unchanged; with one entry the new word replaces the head.
               if (cnt_q == 2'd1) head_q <= new_e;
               else begin
                  head_q <= tail_q;
                  tail_q <= new_e;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Directed bench for alu_instr_encoder: default instance plus an ADDR_W=4
// instance for address wrap.
module tb_alu_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        restart = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_kind = '0;
   logic [2:0]  in_alu = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [12:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [7:0]  out_addr;
   logic        err;
   logic [15:0] emitted;

   logic        restart4 = 1'b0;
   logic        in_valid4 = 1'b0;
   logic        in_ready4;
   logic        out_valid4;
   logic        out_ready4 = 1'b1;
   logic [31:0] out_instr4;
   logic [3:0]  out_addr4;
   logic        err4;
   logic [15:0] emitted4;

   int checks = 0;
   int errors = 0;
   int exp_em = 0;

   always #5 clk = ~clk;

   alu_instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .restart(restart),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_alu(in_alu),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .err(err), .emitted(emitted)
   );

   alu_instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dut4 (
      .clk(clk), .rst_n(rst_n), .restart(restart4),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_kind(in_kind), .in_alu(in_alu),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_instr(out_instr4),
      .out_addr(out_addr4), .err(err4), .emitted(emitted4)
   );

   task automatic set_req(input logic [1:0] k, input logic [2:0] a, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
      in_kind = k; in_alu = a; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_restart();
      in_valid = 1'b0;
      restart = 1'b1;
      tick();
      restart = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h want 00000000", out_instr); end
      checks++; if (out_addr !== 8'h00) begin errors++; $display("FAIL reset_out_addr: got %h want 00", out_addr); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (emitted !== 16'h0) begin errors++; $display("FAIL reset_emitted: got %0d want 0", emitted); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      tick();
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      set_req(2'b10, 3'b000, 5'd3, 5'd1, 5'd2, 13'h0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      checks++; if (out_instr !== 32'h002081B3) begin errors++; $display("FAIL basic_instr: got %h want 002081b3", out_instr); end
      checks++; if (out_addr !== 8'h00) begin errors++; $display("FAIL basic_addr: got %h want 00", out_addr); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err); end
      tick();
      exp_em = 1;
      checks++; if (emitted !== 16'(exp_em)) begin errors++; $display("FAIL basic_emitted: got %0d want %0d", emitted, exp_em); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_alu_ops();
      logic [2:0]  ops [3];
      logic [31:0] exp [3];
      ops = '{3'b010, 3'b011, 3'b100};
      exp = '{32'h0020F1B3, 32'h0020E1B3, 32'h0020A1B3};
      do_restart();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_req(2'b10, ops[i], 5'd3, 5'd1, 5'd2, 13'h0);
         in_valid = 1'b1;
         tick();
         checks++; if (out_instr !== exp[i]) begin errors++; $display("FAIL alu_op%0d_instr: got %h want %h", i, out_instr, exp[i]); end
      end
      in_valid = 1'b0;
      tick();
      exp_em += 3;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_i [4];
      exp_i = '{32'h407302B3, 32'h0080A203, 32'h0020A623, 32'hFE208CE3};
      do_restart();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: set_req(2'b10, 3'b001, 5'd5, 5'd6, 5'd7, 13'h0);
            1: set_req(2'b00, 3'b000, 5'd4, 5'd1, 5'd9, 13'h1008); // rs2, imm[12] ignored
            2: set_req(2'b01, 3'b000, 5'd9, 5'd1, 5'd2, 13'h000C); // rd ignored
            default: set_req(2'b11, 3'b000, 5'd0, 5'd1, 5'd2, 13'h1FF8);
         endcase
         in_valid = 1'b1;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
         @(posedge clk); #1;
         checks++; if (out_instr !== exp_i[i]) begin errors++; $display("FAIL b2b_instr%0d: got %h want %h", i, out_instr, exp_i[i]); end
         checks++; if (out_addr !== 8'(i * 4)) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", i, out_addr, 8'(i * 4)); end
         checks++; if (emitted !== 16'(exp_em + i)) begin errors++; $display("FAIL b2b_emitted%0d: got %0d want %0d", i, emitted, exp_em + i); end
      end
      in_valid = 1'b0;
      tick();
      exp_em += 4;
      checks++; if (emitted !== 16'(exp_em)) begin errors++; $display("FAIL b2b_emitted_end: got %0d want %0d", emitted, exp_em); end
   endtask

   task automatic test_backpressure();
      do_restart();
      out_ready = 1'b0;
      set_req(2'b10, 3'b000, 5'd3, 5'd1, 5'd2, 13'h0);
      in_valid = 1'b1;
      tick();
      set_req(2'b00, 3'b000, 5'd4, 5'd1, 5'd0, 13'h0008);
      tick();
      set_req(2'b01, 3'b000, 5'd0, 5'd1, 5'd2, 13'h000C);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
      tick();
      checks++; if (out_instr !== 32'h002081B3) begin errors++; $display("FAIL bp_head_held: got %h want 002081b3", out_instr); end
      checks++; if (out_addr !== 8'h00) begin errors++; $display("FAIL bp_head_addr: got %h want 00", out_addr); end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_instr !== 32'h0080A203 || out_addr !== 8'h04) begin errors++; $display("FAIL bp_second: got %h@%h want 0080a203@04", out_instr, out_addr); end
      tick();
      checks++; if (out_instr !== 32'h0020A623 || out_addr !== 8'h08) begin errors++; $display("FAIL bp_third: got %h@%h want 0020a623@08", out_instr, out_addr); end
      tick();
      exp_em += 3;
      checks++; if (out_valid !== 1'b0 || emitted !== 16'(exp_em)) begin errors++; $display("FAIL bp_drain: got v=%b em=%0d want v=0 em=%0d", out_valid, emitted, exp_em); end
   endtask

   task automatic test_illegal();
      do_restart();
      out_ready = 1'b1;
      set_req(2'b10, 3'b101, 5'd3, 5'd1, 5'd2, 13'h0);
      in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ill_alu: got err=%b v=%b want err=1 v=0", err, out_valid); end
      tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_pulse_len: got %b want 0", err); end
      set_req(2'b11, 3'b000, 5'd0, 5'd1, 5'd2, 13'h0005);
      in_valid = 1'b1;
      tick();
      checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ill_beq: got err=%b v=%b want err=1 v=0", err, out_valid); end
      set_req(2'b10, 3'b000, 5'd3, 5'd1, 5'd2, 13'h0);
      tick();
      in_valid = 1'b0;
      checks++; if (err !== 1'b0 || out_valid !== 1'b1 || out_addr !== 8'h00) begin errors++; $display("FAIL ill_next_legal: got err=%b v=%b a=%h want err=0 v=1 a=00", err, out_valid, out_addr); end
      tick();
      exp_em += 1;
   endtask

   task automatic test_wrap();
      set_req(2'b10, 3'b000, 5'd3, 5'd1, 5'd2, 13'h0);
      for (int i = 0; i < 5; i++) begin
         in_valid4 = 1'b1;
         tick();
         checks++; if (out_valid4 !== 1'b1 || out_addr4 !== 4'(i * 4)) begin errors++; $display("FAIL wrap_addr%0d: got v=%b a=%h want v=1 a=%h", i, out_valid4, out_addr4, 4'(i * 4)); end
      end
      in_valid4 = 1'b0;
      tick();
   endtask

   task automatic test_restart();
      do_restart();
      out_ready = 1'b0;
      set_req(2'b10, 3'b000, 5'd3, 5'd1, 5'd2, 13'h0);
      in_valid = 1'b1;
      tick();
      tick();
      out_ready = 1'b1;
      restart = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", in_ready); end
      @(posedge clk); #1;
      restart = 1'b0;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || emitted !== 16'(exp_em)) begin errors++; $display("FAIL rst_clear: got v=%b em=%0d want v=0 em=%0d", out_valid, emitted, exp_em); end
      set_req(2'b00, 3'b000, 5'd4, 5'd1, 5'd0, 13'h0008);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_instr !== 32'h0080A203 || out_addr !== 8'h00) begin errors++; $display("FAIL rst_next: got %h@%h want 0080a203@00", out_instr, out_addr); end
      tick();
      exp_em += 1;
      checks++; if (emitted !== 16'(exp_em)) begin errors++; $display("FAIL rst_emitted: got %0d want %0d", emitted, exp_em); end
   endtask

   task automatic test_async_reset();
      do_restart();
      out_ready = 1'b0;
      set_req(2'b10, 3'b000, 5'd3, 5'd1, 5'd2, 13'h0);
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL ar_full: got v=%b r=%b want v=1 r=0", out_valid, in_ready); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || emitted !== 16'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL ar_immediate: got v=%b em=%0d i=%h want 0/0/0", out_valid, emitted, out_instr); end
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) tick();
      checks++; if (out_valid !== 1'b0 || emitted !== 16'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL ar_after: got v=%b em=%0d r=%b want 0/0/1", out_valid, emitted, in_ready); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_alu_ops();
      test_back_to_back();
      test_backpressure();
      test_illegal();
      test_wrap();
      test_restart();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
